// File: rtl/debug_pkg.sv
// Shared types and constants for the debug abstract command sequencer:
// cmderr codes, abstract command field positions, regno map and FSM states.
package debug_pkg;

   typedef enum logic [2:0] {
      CMDERR_NONE       = 3'd0,
      CMDERR_BUSY       = 3'd1,
      CMDERR_NOTSUP     = 3'd2,
      CMDERR_EXCEPT     = 3'd3,
      CMDERR_HALTRESUME = 3'd4
   } cmderr_e;

   localparam int CMD_TYPE_MSB  = 31;
   localparam int CMD_TYPE_LSB  = 24;
   localparam int CMD_SIZE_MSB  = 22;
   localparam int CMD_SIZE_LSB  = 20;
   localparam int CMD_POSTEXEC  = 18;
   localparam int CMD_TRANSFER  = 17;
   localparam int CMD_WRITE     = 16;
   localparam int CMD_REGNO_MSB = 15;
   localparam int CMD_REGNO_LSB = 0;

   localparam logic [2:0] AARSIZE_32 = 3'd2;

   localparam logic [15:0] REGNO_CSR_BASE  = 16'h0000;
   localparam logic [15:0] REGNO_CSR_LIMIT = 16'h0FFF;
   localparam logic [15:0] REGNO_GPR_BASE  = 16'h1000;
   localparam logic [15:0] REGNO_GPR_LIMIT = 16'h101F;
   localparam logic [15:0] REGNO_DCSR      = 16'h07B0;
   localparam logic [15:0] REGNO_DPC       = 16'h07B1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_ACCESS,
      ST_RDATA,
      ST_DONE
   } abs_state_e;

   // CSR window starts at zero, so only its upper bound needs comparing.
   function automatic logic regno_supported(input logic [15:0] regno);
      return (regno <= REGNO_CSR_LIMIT) ||
             ((regno >= REGNO_GPR_BASE) && (regno <= REGNO_GPR_LIMIT));
   endfunction

endpackage

// File: rtl/dbg_abs_cmd_decode.sv
// Combinational check of a latched Access Register command against halt
// state and the supported register map.
module dbg_abs_cmd_decode
   import debug_pkg::*;
(
   input  logic [31:0] cmd_i,
   input  logic        core_halted_i,
   output logic [2:0]  err_o,
   output logic        access_o,
   output logic        read_o
);

   cmderr_e err;
   logic    transfer;
   logic    unused_bits;

   assign transfer    = cmd_i[CMD_TRANSFER];
   assign unused_bits = ^{cmd_i[23], cmd_i[19]};

   // Checks are ordered by priority; the first failing one wins.
   always_comb begin
      err = CMDERR_NONE;
      if (cmd_i[CMD_TYPE_MSB:CMD_TYPE_LSB] != '0) begin
         err = CMDERR_NOTSUP;
      end else if (cmd_i[CMD_POSTEXEC]) begin
         err = CMDERR_NOTSUP;
      end else if (transfer && (cmd_i[CMD_SIZE_MSB:CMD_SIZE_LSB] != AARSIZE_32)) begin
         err = CMDERR_NOTSUP;
      end else if (!core_halted_i) begin
         err = CMDERR_HALTRESUME;
      end else if (transfer && !regno_supported(cmd_i[CMD_REGNO_MSB:CMD_REGNO_LSB])) begin
         err = CMDERR_EXCEPT;
      end
   end

   assign err_o    = err;
   assign access_o = (err == CMDERR_NONE) && transfer;
   assign read_o   = !cmd_i[CMD_WRITE];

endmodule

// File: rtl/dbg_abstract_ctrl.sv
// Abstract command sequencer between the DMI command/data0/abstractcs
// registers and the core's register access port. Optional feature:
// DBG_AUTOEXEC_EN enables abstractauto.autoexecdata[0].
module dbg_abstract_ctrl
   import debug_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              cmd_wr_i,
   input  logic [31:0]       cmd_i,
   input  logic              data0_wr_i,
   input  logic              data0_rd_i,
   input  logic [DATA_W-1:0] data0_wdata_i,
   output logic [DATA_W-1:0] data0_o,
   input  logic [2:0]        cmderr_clr_i,
   input  logic              autoexec_wr_i,
   input  logic              autoexec_i,
   output logic              busy_o,
   output logic [2:0]        cmderr_o,
   input  logic              core_halted_i,
   output logic              ar_en_o,
   output logic              ar_wr_o,
   output logic [15:0]       ar_ad_o,
   output logic [DATA_W-1:0] ar_do_o,
   input  logic [DATA_W-1:0] ar_di_i
);

   abs_state_e        state_q, state_d;
   logic [31:0]       cmd_q, cmd_d;
   logic [DATA_W-1:0] data0_q, data0_d;
   cmderr_e           cmderr_q, cmderr_d;
   logic              autoexec_q, autoexec_d;

   logic [2:0] dec_err;
   logic       dec_access;
   logic       dec_read;
   logic       ae_trig;

   dbg_abs_cmd_decode u_decode (
      .cmd_i         (cmd_q),
      .core_halted_i (core_halted_i),
      .err_o         (dec_err),
      .access_o      (dec_access),
      .read_o        (dec_read)
   );

`ifdef DBG_AUTOEXEC_EN
   assign ae_trig = autoexec_q && (data0_rd_i || data0_wr_i);
`else
   logic unused_ae;
   assign ae_trig   = 1'b0;
   assign unused_ae = ^{autoexec_wr_i, autoexec_i, data0_rd_i, autoexec_q};
`endif

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      data0_d    = data0_q;
      cmderr_d   = cmderr_e'(cmderr_q & ~cmderr_clr_i);
      autoexec_d = autoexec_q;
      ar_en_o    = 1'b0;
      ar_wr_o    = 1'b0;
      ar_ad_o    = '0;
      ar_do_o    = '0;

`ifdef DBG_AUTOEXEC_EN
      if (autoexec_wr_i) autoexec_d = autoexec_i;
`endif

      case (state_q)
         ST_IDLE: begin
            if (data0_wr_i) data0_d = data0_wdata_i;
            if (cmd_wr_i) begin
               if (cmderr_q == CMDERR_NONE) begin
                  cmd_d   = cmd_i;
                  state_d = ST_DECODE;
               end
            end else if (ae_trig && (cmderr_q == CMDERR_NONE)) begin
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (cmderr_e'(dec_err) != CMDERR_NONE) begin
               if (cmderr_d == CMDERR_NONE) cmderr_d = cmderr_e'(dec_err);
               state_d = ST_DONE;
            end else if (dec_access) begin
               state_d = ST_ACCESS;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_ACCESS: begin
            ar_en_o = 1'b1;
            ar_wr_o = cmd_q[CMD_WRITE];
            ar_ad_o = cmd_q[CMD_REGNO_MSB:CMD_REGNO_LSB];
            ar_do_o = data0_q;
            if (!core_halted_i && (cmderr_d == CMDERR_NONE)) cmderr_d = CMDERR_HALTRESUME;
            state_d = dec_read ? ST_RDATA : ST_DONE;
         end
         ST_RDATA: begin
            // Read data from a core that dropped out of halt is not trusted.
            if (core_halted_i) begin
               data0_d = ar_di_i;
            end else if (cmderr_d == CMDERR_NONE) begin
               cmderr_d = CMDERR_HALTRESUME;
            end
            state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if ((state_q != ST_IDLE) && (cmd_wr_i || data0_wr_i) && (cmderr_d == CMDERR_NONE))
         cmderr_d = CMDERR_BUSY;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= ST_IDLE;
         cmd_q      <= '0;
         data0_q    <= '0;
         cmderr_q   <= CMDERR_NONE;
         autoexec_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         data0_q    <= data0_d;
         cmderr_q   <= cmderr_d;
         autoexec_q <= autoexec_d;
      end
   end

   assign busy_o   = (state_q != ST_IDLE);
   assign cmderr_o = cmderr_q;
   assign data0_o  = data0_q;

endmodule

// File: tb/tb_dbg_abstract_ctrl.sv
// Randomized self-checking bench for dbg_abstract_ctrl against a
// command-level reference model (error rules, latencies, data0, cmderr).
module tb_dbg_abstract_ctrl;

`ifdef DBG_AUTOEXEC_EN
   localparam bit AE_EN = 1'b1;
`else
   localparam bit AE_EN = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        reset_ni = 1'b0;
   logic        cmd_wr_i = 1'b0;
   logic [31:0] cmd_i = '0;
   logic        data0_wr_i = 1'b0;
   logic        data0_rd_i = 1'b0;
   logic [31:0] data0_wdata_i = '0;
   logic [31:0] data0_o;
   logic [2:0]  cmderr_clr_i = '0;
   logic        autoexec_wr_i = 1'b0;
   logic        autoexec_i = 1'b0;
   logic        busy_o;
   logic [2:0]  cmderr_o;
   logic        core_halted_i = 1'b1;
   logic        ar_en_o;
   logic        ar_wr_o;
   logic [15:0] ar_ad_o;
   logic [31:0] ar_do_o;
   logic [31:0] ar_di_i = '0;

   dbg_abstract_ctrl #(.DATA_W(32)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni),
      .cmd_wr_i(cmd_wr_i), .cmd_i(cmd_i),
      .data0_wr_i(data0_wr_i), .data0_rd_i(data0_rd_i),
      .data0_wdata_i(data0_wdata_i), .data0_o(data0_o),
      .cmderr_clr_i(cmderr_clr_i),
      .autoexec_wr_i(autoexec_wr_i), .autoexec_i(autoexec_i),
      .busy_o(busy_o), .cmderr_o(cmderr_o),
      .core_halted_i(core_halted_i),
      .ar_en_o(ar_en_o), .ar_wr_o(ar_wr_o), .ar_ad_o(ar_ad_o),
      .ar_do_o(ar_do_o), .ar_di_i(ar_di_i)
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   logic [31:0] m_d0 = '0;
   int          m_err = 0;
   logic [31:0] m_last = '0;
   bit          m_ae = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic int exp_err(input logic [31:0] c, input bit halted);
      if (c[31:24] != 8'd0 || c[18] || (c[17] && c[22:20] != 3'd2)) return 2;
      if (!halted) return 4;
      if (c[17] && c[15:0] > 16'h101F) return 3;
      return 0;
   endfunction

   task automatic wr_data0(input logic [31:0] v);
      @(posedge clk_i); #1;
      data0_wr_i = 1'b1; data0_wdata_i = v;
      @(posedge clk_i); #1;
      data0_wr_i = 1'b0;
      m_d0 = v;
      @(negedge clk_i);
      chk("data0_wr", data0_o, m_d0);
   endtask

   task automatic clear_err(input logic [2:0] mask);
      @(posedge clk_i); #1;
      cmderr_clr_i = mask;
      @(posedge clk_i); #1;
      cmderr_clr_i = '0;
      m_err = m_err & ~int'(mask);
      @(negedge clk_i);
      chk("cmderr_clr", {29'd0, cmderr_o}, m_err);
   endtask

   task automatic set_autoexec(input bit v);
      @(posedge clk_i); #1;
      autoexec_wr_i = 1'b1; autoexec_i = v;
      @(posedge clk_i); #1;
      autoexec_wr_i = 1'b0;
      m_ae = v;
   endtask

   // kind 0: DMI command write; kind 1: data0 read (autoexec trigger).
   // viol: cycle at which cmd_wr+data0_wr are pulsed while busy (0 none).
   // drop: cycle at which the core leaves halt (0 none).
   task automatic run_cmd(input int kind, input logic [31:0] cmd, input logic [31:0] di,
                          input int viol, input int drop);
      bit go, access, rd, h0, b1;
      logic [31:0] ec, s_wr, s_ad, s_do;
      int e, exp_busy, busy_cnt, en_cnt, en_cyc, ce2;
      h0 = core_halted_i;
      go = (kind == 0) ? (m_err == 0) : (AE_EN && m_ae && m_err == 0);
      ec = (kind == 0) ? cmd : m_last;
      if (go) m_last = ec;
      e = exp_err(ec, h0);
      access = go && e == 0 && ec[17];
      rd = access && !ec[16];
      exp_busy = !go ? 0 : (!access ? 2 : (rd ? 4 : 3));
      busy_cnt = 0; en_cnt = 0; en_cyc = 0; ce2 = 0; b1 = 0;
      s_wr = '0; s_ad = '0; s_do = '0;

      @(posedge clk_i); #1;
      if (kind == 0) begin cmd_i = cmd; cmd_wr_i = 1'b1; end
      else data0_rd_i = 1'b1;
      ar_di_i = di;
      @(posedge clk_i); #1;
      cmd_wr_i = 1'b0; data0_rd_i = 1'b0;
      for (int cy = 1; cy <= 8; cy++) begin
         @(negedge clk_i);
         cmd_wr_i = 1'b0; data0_wr_i = 1'b0;
         if (busy_o) busy_cnt++;
         if (cy == 1) b1 = busy_o;
         if (cy == 2) ce2 = int'(cmderr_o);
         if (ar_en_o) begin
            en_cnt++; en_cyc = cy;
            s_wr = {31'd0, ar_wr_o}; s_ad = {16'd0, ar_ad_o}; s_do = ar_do_o;
         end
         if (cy == viol) begin
            cmd_wr_i = 1'b1; data0_wr_i = 1'b1; data0_wdata_i = 32'hBAD0_BAD0;
         end
         if (cy == drop) core_halted_i = 1'b0;
      end
      core_halted_i = h0;

      if (go && e != 0) m_err = e;
      if (access && (drop == 2 || (rd && drop == 3))) begin
         if (m_err == 0) m_err = 4;
      end else if (rd) begin
         m_d0 = di;
      end
      if (viol != 0 && go && m_err == 0) m_err = 1;

      chk("busy_c1", {31'd0, b1}, {31'd0, exp_busy > 0});
      chk("busy_cycles", busy_cnt, exp_busy);
      chk("ar_en_count", en_cnt, access ? 1 : 0);
      if (access) begin
         chk("ar_en_cycle", en_cyc, 2);
         chk("ar_wr", s_wr, {31'd0, ec[16]});
         chk("ar_ad", s_ad, {16'd0, ec[15:0]});
         chk("ar_do", s_do, ec[16] ? m_d0 : s_do == s_do ? m_d0_prev(ec, s_do) : '0);
      end
      if (go && e != 0 && viol == 0) chk("cmderr_c2", ce2, e);
      chk("cmderr", {29'd0, cmderr_o}, m_err);
      chk("data0", data0_o, m_d0);
   endtask

   // ar_do carries data0 as it was before the access; for reads the model
   // has already advanced data0, so the pre-command value is kept here.
   logic [31:0] pre_d0;
   function automatic logic [31:0] m_d0_prev(input logic [31:0] c, input logic [31:0] unused_v);
      return pre_d0;
   endfunction

   task automatic run(input int kind, input logic [31:0] cmd, input logic [31:0] di,
                      input int viol, input int drop);
      pre_d0 = m_d0;
      run_cmd(kind, cmd, di, viol, drop);
   endtask

   initial begin
      logic [31:0] c;
      logic [2:0]  mask;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_cmderr", {29'd0, cmderr_o}, 32'd0);
      chk("rst_data0", data0_o, 32'd0);
      chk("rst_ar_en", {31'd0, ar_en_o}, 32'd0);
      chk("rst_ar_ad", {16'd0, ar_ad_o}, 32'd0);
      chk("rst_ar_do", ar_do_o, 32'd0);
      reset_ni = 1'b1;

      core_halted_i = 1'b1;
      wr_data0(32'hDEADBEEF);
      run(0, 32'h00231000, 32'h0, 0, 0);
      run(0, 32'h002207B1, 32'h80000040, 0, 0);

      core_halted_i = 1'b0;
      run(0, 32'h00221001, 32'h11111111, 0, 0);
      core_halted_i = 1'b1;
      run(0, 32'h00231000, 32'h0, 0, 0);
      clear_err(3'b111);
      run(0, 32'h00231000, 32'h0, 0, 0);

      run(0, 32'h00321000, 32'h0, 0, 0);
      clear_err(3'b111);
      run(0, 32'h00222000, 32'h0, 0, 0);
      clear_err(3'b111);
      run(0, 32'h01221000, 32'h0, 0, 0);
      clear_err(3'b111);
      run(0, 32'h00201000, 32'h0, 0, 0);

      run(0, 32'h00221002, 32'h12345678, 2, 0);
      clear_err(3'b111);
      run(0, 32'h00221003, 32'h55AA55AA, 0, 3);
      clear_err(3'b111);

      for (int i = 0; i < 40; i++) begin
         core_halted_i = ($urandom_range(0, 7) != 0);
         if (m_err != 0 && $urandom_range(0, 2) != 0) begin
            mask = 3'($urandom_range(0, 7));
            clear_err(mask);
         end
         if ($urandom_range(0, 3) == 0) wr_data0($urandom);
         c = '0;
         if ($urandom_range(0, 9) == 0) c[31:24] = 8'($urandom_range(1, 255));
         c[18] = ($urandom_range(0, 9) == 0);
         c[22:20] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
         c[17] = ($urandom_range(0, 5) != 0);
         c[16] = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0: c[15:0] = 16'($urandom_range(0, 32'h0FFF));
            1: c[15:0] = 16'($urandom_range(32'h1000, 32'h101F));
            2: c[15:0] = 16'($urandom_range(32'h07B0, 32'h07B1));
            default: c[15:0] = 16'($urandom_range(32'h1020, 32'hFFFF));
         endcase
         run(0, c, $urandom, 0, 0);
      end
      core_halted_i = 1'b1;
      clear_err(3'b111);

      // asynchronous reset in the middle of a write access
      @(posedge clk_i); #1;
      cmd_i = 32'h00231000; cmd_wr_i = 1'b1;
      @(posedge clk_i); #1;
      cmd_wr_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      chk("mid_ar_en", {31'd0, ar_en_o}, 32'd1);
      reset_ni = 1'b0;
      #1;
      chk("mid_rst_ar_en", {31'd0, ar_en_o}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
      chk("mid_rst_data0", data0_o, 32'd0);
      m_d0 = '0; m_err = 0; m_last = '0; m_ae = 1'b0;
      @(posedge clk_i); #1;
      reset_ni = 1'b1;

      set_autoexec(1'b1);
      run(0, 32'h00221005, 32'hCAFE0005, 0, 0);
      run(1, 32'h0, 32'hCAFE1005, 0, 0);
      set_autoexec(1'b0);
      run(1, 32'h0, 32'hCAFE2005, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
